// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Brief    : Weight loader, skewed activation feeder, result de-skew and
//            result FIFO for a 4x4 weight-stationary systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 num_vecs,
  output logic                       busy,
  output logic                       done,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [3:0][WIDTH-1:0]      w_data,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [3:0][WIDTH-1:0]      x_data,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [3:0][WIDTH-1:0]      y_data,
  output logic [3:0][3:0][WIDTH-1:0] arr_weights,
  output logic [3:0][WIDTH-1:0]      arr_in_left,
  output logic [3:0][WIDTH-1:0]      arr_in_up,
  input  logic [3:0][WIDTH-1:0]      arr_out_down
);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_load_w = 3'd1;
  localparam logic [2:0] c_stream = 3'd2;
  localparam logic [2:0] c_drain  = 3'd3;
  localparam logic [2:0] c_done   = 3'd4;

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_sum_w = c_cnt_w + 1;
  localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(FIFO_DEPTH);

  logic [2:0]                 state_q, state_d;
  logic [7:0]                 num_q, num_d;
  logic [7:0]                 acc_q, acc_d;
  logic [1:0]                 wrow_q, wrow_d;
  logic [3:0][3:0][WIDTH-1:0] weights_q, weights_d;
  logic [7:0]                 trk_q, trk_d;
  logic [c_cnt_w-1:0]         count_q, count_d;
  logic [c_ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
  logic [3:0][WIDTH-1:0]      fifo_q [FIFO_DEPTH];
  logic [3:0][WIDTH-1:0]      fifo_d [FIFO_DEPTH];
  logic [3:0][WIDTH-1:0]      aligned;
  logic [3:0][WIDTH-1:0]      lane_out;
  logic [3:0]                 inflight;
  logic [c_sum_w-1:0]         occupancy;
  logic                       w_fire, x_fire, y_fire, push;

  assign w_fire      = w_valid & w_ready;
  assign x_fire      = x_valid & x_ready;
  assign y_fire      = y_valid & y_ready;
  assign push        = trk_q[7];
  assign y_valid     = (count_q != '0);
  assign y_data      = fifo_q[rd_ptr_q];
  assign arr_weights = weights_q;
  assign arr_in_left = lane_out;
  assign arr_in_up   = '0;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= c_idle;
    else     state_q <= state_d;
  end

  // DRAIN looks at next-cycle occupancy so done follows the last pop directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:   if (start) state_d = c_load_w;
      c_load_w: if (w_fire && wrow_q == 2'd3) state_d = c_stream;
      c_stream: if (acc_q == num_q) state_d = c_drain;
      c_drain:  if (trk_d == '0 && count_d == '0) state_d = c_done;
      c_done:   state_d = c_idle;
      default:  state_d = c_idle;
    endcase
  end

  always_comb begin
    busy    = (state_q != c_idle);
    done    = (state_q == c_done);
    w_ready = (state_q == c_load_w);
    x_ready = (state_q == c_stream) && (acc_q < num_q) && (occupancy < c_depth);
  end

  // ------------------------------------------------ job control / weights
  always_comb begin
    inflight = '0;
    for (int i = 0; i < 8; i++) inflight = inflight + {3'b000, trk_q[i]};
    occupancy = c_sum_w'(inflight) + c_sum_w'(count_q);
  end

  always_comb begin
    num_d     = num_q;
    acc_d     = acc_q;
    wrow_d    = wrow_q;
    weights_d = weights_q;
    if (state_q == c_idle && start) begin
      num_d  = num_vecs;
      acc_d  = '0;
      wrow_d = '0;
    end
    if (w_fire) begin
      weights_d[wrow_q] = w_data;
      wrow_d            = wrow_q + 2'd1;
    end
    if (x_fire) acc_d = acc_q + 8'd1;
    trk_d = {trk_q[6:0], x_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q     <= '0;
      acc_q     <= '0;
      wrow_q    <= '0;
      weights_q <= '0;
      trk_q     <= '0;
    end else begin
      num_q     <= num_d;
      acc_q     <= acc_d;
      wrow_q    <= wrow_d;
      weights_q <= weights_d;
      trk_q     <= trk_d;
    end
  end

  // ------------------------------------------- input skew: lane r = r+1 flops
  for (genvar r = 0; r < 4; r++) begin : g_lane
    logic [WIDTH-1:0] stg_q [r+1];
    logic [WIDTH-1:0] stg_d [r+1];

    always_comb begin
      stg_d[0] = x_fire ? x_data[r] : '0;
      for (int s = 1; s <= r; s++) stg_d[s] = stg_q[s-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= r; s++) stg_q[s] <= '0;
      end else begin
        stg_q <= stg_d;
      end
    end

    assign lane_out[r] = stg_q[r];
  end

  // ---------------------------------------- output de-skew: col c = 3-c flops
  for (genvar c = 0; c < 4; c++) begin : g_deskew
    if (c < 3) begin : g_stages
      logic [WIDTH-1:0] ds_q [3-c];
      logic [WIDTH-1:0] ds_d [3-c];

      always_comb begin
        ds_d[0] = arr_out_down[c];
        for (int s = 1; s < 3 - c; s++) ds_d[s] = ds_q[s-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < 3 - c; s++) ds_q[s] <= '0;
        end else begin
          ds_q <= ds_d;
        end
      end

      assign aligned[c] = ds_q[2-c];
    end else begin : g_direct
      assign aligned[c] = arr_out_down[c];
    end
  end

  // -------------------------------------------------------------- result FIFO
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = aligned;
      wr_ptr_d         = wr_ptr_q + c_ptr_w'(1);
    end
    if (y_fire) rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    if (push && !y_fire)      count_d = count_q + c_cnt_w'(1);
    else if (!push && y_fire) count_d = count_q - c_cnt_w'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_sequencer
// Brief    : Directed self-checking bench; includes a behavioural 4x4
//            weight-stationary array wired to the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_sequencer;

  logic                   clk, rst, start;
  logic [7:0]             num_vecs;
  logic                   busy, done;
  logic                   w_valid, w_ready, x_valid, x_ready, y_valid, y_ready;
  logic [3:0][15:0]       w_data, x_data, y_data;
  logic [3:0][3:0][15:0]  arr_weights;
  logic [3:0][15:0]       arr_in_left, arr_in_up, arr_out_down;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [3:0][15:0] cap_data [$];
  int               cap_cyc  [$];
  int               x_cyc    [$];

  systolic_sequencer #(.WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .arr_weights(arr_weights), .arr_in_left(arr_in_left),
    .arr_in_up(arr_in_up), .arr_out_down(arr_out_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array: activations move right, partial sums move down, one PE per cycle
  logic [3:0][3:0][15:0] a_q, p_q;
  always @(posedge clk) begin
    logic [15:0] ain, pin;
    if (rst) begin
      a_q <= '0;
      p_q <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (c == 0) ain = arr_in_left[r]; else ain = a_q[r][c-1];
          if (r == 0) pin = arr_in_up[c];   else pin = p_q[r-1][c];
          a_q[r][c] <= ain;
          p_q[r][c] <= pin + ain * arr_weights[r][c];
        end
      end
    end
  end
  assign arr_out_down = p_q[3];

  always @(negedge clk) begin
    if (!rst) begin
      if (y_valid && y_ready) begin
        cap_data.push_back(y_data);
        cap_cyc.push_back(cyc);
      end
      if (x_valid && x_ready) x_cyc.push_back(cyc);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0][15:0] mk(input int a0, input int a1, input int a2, input int a3);
    logic [3:0][15:0] v;
    v[0] = a0[15:0]; v[1] = a1[15:0]; v[2] = a2[15:0]; v[3] = a3[15:0];
    return v;
  endfunction

  function automatic logic [3:0][3:0][15:0] ident();
    logic [3:0][3:0][15:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = (r == c) ? 16'd1 : 16'd0;
    return m;
  endfunction

  function automatic logic [3:0][15:0] golden(input logic [3:0][15:0] x, input logic [3:0][3:0][15:0] w);
    logic [3:0][15:0] res;
    int acc;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int r = 0; r < 4; r++) acc = acc + int'($signed(x[r])) * int'($signed(w[r][c]));
      res[c] = acc[15:0];
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_cyc.delete();
    x_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input logic [7:0] n, input logic [3:0][3:0][15:0] w);
    int k, t;
    logic f;
    start = 1'b1; num_vecs = n; tick(); start = 1'b0;
    k = 0; t = 0;
    while (k < 4 && t < 20) begin
      w_valid = 1'b1; w_data = w[k];
      @(negedge clk); f = w_ready;
      tick(); t++;
      if (f) k++;
    end
    w_valid = 1'b0;
    if (k != 4) begin
      n_checks++;
      $display("FAIL weight_load: got %0d rows accepted, expected 4", k);
    end
  endtask

  task automatic send_x(input logic [3:0][15:0] v, input int bound);
    int t;
    logic f;
    x_valid = 1'b1; x_data = v; f = 1'b0; t = 0;
    while (!f && t < bound) begin
      @(negedge clk); f = x_ready;
      tick(); t++;
    end
    x_valid = 1'b0;
    if (!f) begin
      n_checks++;
      $display("FAIL x_handshake: got no x_ready within %0d cycles, expected acceptance", bound);
    end
  endtask

  task automatic wait_caps(input int n, input int bound);
    int t = 0;
    while (cap_data.size() < n && t < bound) begin tick(); t++; end
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (busy && t < bound) begin tick(); t++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_checks++;
    if ({busy, done, w_ready, x_ready, y_valid} !== 5'b0)
      $display("FAIL reset_flags: got %b, expected 00000", {busy, done, w_ready, x_ready, y_valid});
    else n_pass++;
    n_checks++;
    if (arr_weights !== '0 || arr_in_left !== '0 || arr_in_up !== '0 || y_data !== '0)
      $display("FAIL reset_data: got w=%h l=%h u=%h y=%h, expected all 0", arr_weights, arr_in_left, arr_in_up, y_data);
    else n_pass++;
    rst = 1'b0; tick();
  endtask

  task automatic test_identity();
    clear_caps();
    start_job(8'd1, ident());
    n_checks++;
    if (arr_weights !== ident()) $display("FAIL identity_weights: got %h, expected identity", arr_weights);
    else n_pass++;
    send_x(mk(1, 2, 3, 4), 10);
    wait_caps(1, 30);
    wait_idle(20);
    n_checks++;
    if (cap_data.size() !== 1) $display("FAIL identity_count: got %0d results, expected 1", cap_data.size());
    else n_pass++;
    n_checks++;
    if (cap_data.size() < 1 || cap_data[0] !== mk(1, 2, 3, 4))
      $display("FAIL identity_value: got %h, expected %h", cap_data.size() ? cap_data[0] : '0, mk(1, 2, 3, 4));
    else n_pass++;
    n_checks++;
    if (cap_cyc.size() < 1 || x_cyc.size() < 1 || cap_cyc[0] - x_cyc[0] !== 9)
      $display("FAIL identity_latency: got %0d cycles, expected 9", (cap_cyc.size() && x_cyc.size()) ? cap_cyc[0] - x_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || cap_cyc.size() < 1 || done_cyc - cap_cyc[0] !== 1)
      $display("FAIL identity_done: got %0d pulses at offset %0d, expected 1 pulse at offset 1", done_cnt, cap_cyc.size() ? done_cyc - cap_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL identity_busy: got %b, expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0][3:0][15:0] w;
    for (int r = 0; r < 4; r++) w[r] = mk(2, 2, 2, 2);
    clear_caps();
    start_job(8'd4, w);
    for (int k = 1; k <= 4; k++) send_x(mk(k, k, k, k), 10);
    wait_caps(4, 30);
    wait_idle(20);
    n_checks++;
    if (x_cyc.size() !== 4 || x_cyc[3] - x_cyc[0] !== 3)
      $display("FAIL b2b_x_ready: got %0d accepts over %0d cycles, expected 4 over 3", x_cyc.size(), x_cyc.size() == 4 ? x_cyc[3] - x_cyc[0] : -1);
    else n_pass++;
    n_checks++;
    if (cap_cyc.size() !== 4 || cap_cyc[3] - cap_cyc[0] !== 3)
      $display("FAIL b2b_throughput: got %0d results over %0d cycles, expected 4 over 3", cap_cyc.size(), cap_cyc.size() == 4 ? cap_cyc[3] - cap_cyc[0] : -1);
    else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (cap_data.size() < k || cap_data[k-1] !== mk(8*k, 8*k, 8*k, 8*k))
        $display("FAIL b2b_value[%0d]: got %h, expected %h", k, cap_data.size() >= k ? cap_data[k-1] : '0, mk(8*k, 8*k, 8*k, 8*k));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    clear_caps();
    y_ready = 1'b0;
    start_job(8'd20, ident());
    fork
      begin
        for (int k = 1; k <= 20; k++) send_x(mk(k, k + 1, k + 2, -k), 300);
      end
      begin
        repeat (40) tick();
        n_checks++;
        if (x_cyc.size() !== 8 || x_ready !== 1'b0)
          $display("FAIL bp_accept_limit: got %0d accepted x_ready=%b, expected 8 accepted x_ready=0", x_cyc.size(), x_ready);
        else n_pass++;
        y_ready = 1'b1;
      end
    join
    wait_caps(20, 100);
    wait_idle(40);
    repeat (10) tick();
    n_checks++;
    if (cap_data.size() !== 20) $display("FAIL bp_count: got %0d results, expected 20", cap_data.size());
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      n_checks++;
      if (cap_data.size() < k || cap_data[k-1] !== mk(k, k + 1, k + 2, -k))
        $display("FAIL bp_value[%0d]: got %h, expected %h", k, cap_data.size() >= k ? cap_data[k-1] : '0, mk(k, k + 1, k + 2, -k));
      else n_pass++;
    end
    n_checks++;
    if (done_cnt !== 1) $display("FAIL bp_done: got %0d pulses, expected 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    logic [3:0][3:0][15:0] w;
    logic [3:0][15:0] xs [6];
    w[0] = mk(3, -2, 5, 1);   w[1] = mk(-7, 4, 0, 2);
    w[2] = mk(6, 1, -3, -5);  w[3] = mk(2, -8, 7, 4);
    xs[0] = mk(1, 2, 3, 4);          xs[1] = mk(-5, 6, -7, 8);
    xs[2] = mk(100, -200, 300, -400); xs[3] = mk(32767, 1, -1, 0);
    xs[4] = mk(-32768, 2, 3, -4);    xs[5] = mk(9, 9, 9, 9);
    clear_caps();
    start_job(8'd6, w);
    for (int k = 0; k < 6; k++) begin
      send_x(xs[k], 10);
      tick();
    end
    wait_caps(6, 40);
    wait_idle(20);
    n_checks++;
    if (cap_data.size() !== 6) $display("FAIL bubble_count: got %0d results, expected 6", cap_data.size());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (cap_data.size() <= k || cap_data[k] !== golden(xs[k], w))
        $display("FAIL bubble_value[%0d]: got %h, expected %h", k, cap_data.size() > k ? cap_data[k] : '0, golden(xs[k], w));
      else n_pass++;
    end
  endtask

  task automatic test_zero_vecs();
    logic [3:0][3:0][15:0] w;
    w[0] = mk(11, 12, 13, 14); w[1] = mk(21, 22, 23, 24);
    w[2] = mk(31, 32, 33, 34); w[3] = mk(41, 42, 43, 44);
    clear_caps();
    start_job(8'd0, w);
    wait_idle(20);
    repeat (5) tick();
    n_checks++;
    if (arr_weights !== w) $display("FAIL zero_weights: got %h, expected %h", arr_weights, w);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1 || cap_data.size() !== 0 || busy !== 1'b0)
      $display("FAIL zero_job: got done=%0d results=%0d busy=%b, expected 1 0 0", done_cnt, cap_data.size(), busy);
    else n_pass++;
  endtask

  task automatic test_negative();
    logic [3:0][3:0][15:0] w;
    logic [3:0][15:0] exp_v [3];
    for (int r = 0; r < 4; r++) w[r] = mk(1, 1, 1, 1);
    exp_v[0] = mk(-32768, -32768, -32768, -32768);
    exp_v[1] = mk(0, 0, 0, 0);
    exp_v[2] = mk(-4, -4, -4, -4);
    clear_caps();
    start_job(8'd3, w);
    send_x(mk(-32768, 0, 0, 0), 10);
    send_x(mk(-32768, -32768, 0, 0), 10);
    send_x(mk(-1, -1, -1, -1), 10);
    wait_caps(3, 30);
    wait_idle(20);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cap_data.size() <= k || cap_data[k] !== exp_v[k])
        $display("FAIL negative[%0d]: got %h, expected %h", k, cap_data.size() > k ? cap_data[k] : '0, exp_v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_start_busy();
    clear_caps();
    start_job(8'd2, ident());
    start = 1'b1; num_vecs = 8'd9; tick(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || arr_weights !== ident())
      $display("FAIL start_busy_state: got busy=%b, expected 1 with weights unchanged", busy);
    else n_pass++;
    send_x(mk(5, 6, 7, 8), 10);
    send_x(mk(9, 10, 11, 12), 10);
    wait_idle(40);
    n_checks++;
    if (busy !== 1'b0 || done_cnt !== 1 || cap_data.size() !== 2)
      $display("FAIL start_busy_job: got busy=%b done=%0d results=%0d, expected 0 1 2", busy, done_cnt, cap_data.size());
    else n_pass++;
  endtask

  task automatic test_reset_midjob();
    logic [3:0][3:0][15:0] w;
    for (int r = 0; r < 4; r++) w[r] = mk(2, 2, 2, 2);
    clear_caps();
    start_job(8'd6, w);
    for (int k = 1; k <= 3; k++) send_x(mk(k, k, k, k), 10);
    rst = 1'b1; tick();
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0 || arr_weights !== '0)
      $display("FAIL midjob_reset: got busy=%b y_valid=%b weights=%h, expected 0 0 0", busy, y_valid, arr_weights);
    else n_pass++;
    rst = 1'b0; tick();
    clear_caps();
    start_job(8'd2, ident());
    send_x(mk(11, 12, 13, 14), 10);
    send_x(mk(21, 22, 23, 24), 10);
    wait_idle(40);
    repeat (15) tick();
    n_checks++;
    if (cap_data.size() !== 2) $display("FAIL post_reset_count: got %0d results, expected 2", cap_data.size());
    else n_pass++;
    n_checks++;
    if (cap_data.size() < 2 || cap_data[0] !== mk(11, 12, 13, 14) || cap_data[1] !== mk(21, 22, 23, 24))
      $display("FAIL post_reset_values: got %h %h, expected %h %h",
               cap_data.size() > 0 ? cap_data[0] : '0, cap_data.size() > 1 ? cap_data[1] : '0,
               mk(11, 12, 13, 14), mk(21, 22, 23, 24));
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vecs = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
    test_reset();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_zero_vecs();
    test_negative();
    test_start_busy();
    test_reset_midjob();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequencer for the 4x4 weight-stationary systolic array. It does four things:
- loads a 4x4 weight matrix,
- streams activation vectors into the array's left edge with the per-row skew the array requires,
- de-skews the bottom-edge partial sums into aligned result vectors,
- buffers results in a FIFO with valid/ready backpressure.

The array has no stall input, so the block admits a vector only when a result slot is reserved for it. It sits between the host/DMA side and the array instance.

## Interface
- WIDTH, 16, data width of activations, weights and results (signed)
- FIFO_DEPTH, 8, result FIFO entries; power of two, ≥ 8
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job start pulse; honoured only in IDLE
- num_vecs  in  8  vectors in the job, sampled on accepted start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on DONE
- w_valid / w_ready  in / out  1  weight-row handshake
- w_data  in  WIDTH×[4]  weight row; row index implied by arrival order 0..3
- x_valid / x_ready  in / out  1  activation-vector handshake
- x_data  in  WIDTH×[4]  activation vector, element r goes to array row r
- y_valid / y_ready  out / in  1  result handshake
- y_data  out  WIDTH×[4]  result vector, element c from array column c
- arr_weights  out  WIDTH×[4][4]  to array weights, held constant between loads
- arr_in_left  out  WIDTH×[4]  to array in_left
- arr_in_up  out  WIDTH×[4]  to array in_up; constant 0
- arr_out_down  in  WIDTH×[4]  from array out_down

## Operation
States and transitions:
- IDLE: start → LOAD_W, latching num_vecs.
- LOAD_W: w_ready=1. Each accepted row k (k=0..3) is written to weight register row k; the 4th acceptance → STREAM.
- STREAM:
  - x_ready = (accepted < num_vecs) && (inflight + fifo_count < FIFO_DEPTH).
  - accepted == num_vecs → DRAIN. If num_vecs == 0, STREAM exits on its first cycle.
- DRAIN: x_ready=0. When inflight == 0 and fifo_count == 0 → DONE.
- DONE: done=1 for one cycle → IDLE.

Datapath rules:
- Skew: lane r is an r-stage register chain with a 1-cycle input register. Cycles with no accepted vector inject 0 into every lane (bubble).
- Tracking: an 8-bit valid shift register tracks inflight vectors; inflight = popcount.
- De-skew: column c of arr_out_down passes through (3−c) register stages. The aligned vector is pushed into the FIFO when the tracker's tail bit is 1. Bubble results are never pushed.
- Arithmetic: the block does no arithmetic; it passes WIDTH-bit signed values through unchanged (array wraps mod 2^WIDTH).
- Weight registers: persist across jobs and are overwritten only by LOAD_W.
- start while busy: ignored.
- Empty/full conditions:
  - x_valid with x_ready=0: no transfer.
  - FIFO never overflows by construction.
  - FIFO empty: y_valid=0.
- Simultaneous FIFO push and pop: the count is unchanged and both complete.
- rst mid-job:
  - state → IDLE;
  - skew, de-skew, tracker and FIFO cleared;
  - weights cleared to 0;
  - any in-flight results discarded.

## Timing
- Reset values:
  - busy, done, w_ready, x_ready, y_valid = 0;
  - arr_in_left, arr_in_up, arr_weights, y_data = 0.
- Weight load: row accepted at edge n is visible on arr_weights after edge n. STREAM begins the cycle after the 4th acceptance.
- Vector accepted at edge t:
  - arr_in_left[r] = x_data[r] during cycle t+1+r;
  - arr_out_down[c] is sampled at edge t+5+c;
  - aligned FIFO push occurs at edge t+8;
  - y_valid is high in cycle t+9 if the FIFO was empty (9-cycle latency).
- Throughput: one vector per cycle when y_ready is held high.
- Ordering: results leave in acceptance order.
- Timing of done:
  - done asserts the cycle after the last result handshake;
  - busy drops the cycle after done.

## Test plan
- Identity weights; num_vecs=1; x=(1,2,3,4), y_ready=1 → y=(1,2,3,4) with y_valid first high 9 cycles after the x handshake; done pulses once.
- Weights all 2; 4 back-to-back vectors x=(k,k,k,k), k=1..4 → y = (8k,8k,8k,8k) in order, x_ready continuously high, one result per cycle.
- Backpressure: y_ready=0, num_vecs=20, FIFO_DEPTH=8 → exactly 8 vectors accepted then x_ready=0. Release y_ready → all 20 results arrive correct and in order; no loss or duplication.
- Bubbles: x_valid toggled every other cycle with random weights and vectors → results match the golden matrix product (mod 2^16), count = num_vecs.
- Boundaries:
  - num_vecs=0 → 4 weight rows accepted, then done with no y_valid;
  - negative values (−32768 × 1) handled;
  - start during busy ignored.
- rst asserted mid-STREAM with 3 inflight vectors → next cycle busy=0, y_valid=0, arr_weights=0. A fresh job afterwards produces only its own results.
